// File: rtl/stream_pkg.sv
// stream_pkg: shared defaults and helpers for the stream link blocks.
//   STREAM_DATA_W - default beat width
//   STREAM_CNT_W  - default width of the debug counters
//   fifo_ptr_w()  - pointer width for a power-of-two FIFO depth
package stream_pkg;

    localparam int STREAM_DATA_W = 32;
    localparam int STREAM_CNT_W  = 16;

    // log2 of the depth, never less than one bit so a pointer always exists.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   push, wr_data - write request and data (ignored when full)
//   pop           - read request (ignored when empty)
//   rd_data       - head entry, valid whenever empty=0
//   full, empty   - occupancy flags derived from the registered count
module sync_fifo
    import stream_pkg::*;
#(
    parameter int DATA_W = STREAM_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = fifo_ptr_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q,  count_d;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head of the queue is presented combinationally (fall-through).
    assign rd_data = mem_q[rd_ptr_q];

    // Depth is a power of two, so pointers simply wrap on overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/stream_slave_fifo.sv
// stream_slave_fifo: receiving end of the valid/ready stream link.
// Buffers upstream beats in a small FIFO, re-presents them downstream, and
// checks that accepted beats form a +1 incrementing sequence.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   s_data/s_valid/s_ready - upstream stream (s_ready is backpressure)
//   m_data/m_valid/m_ready - downstream stream, head of the FIFO
//   beat_cnt             - accepted upstream beats, wraps
//   seq_err_cnt          - detected sequence breaks, saturates
//   seq_err              - one-cycle pulse after accepting an out-of-order beat
module stream_slave_fifo
    import stream_pkg::*;
#(
    parameter int DATA_W = STREAM_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = STREAM_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  seq_err_cnt,
    output logic              seq_err
);

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    logic              seen_q,     seen_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q,  err_cnt_d;
    logic              seq_err_q,  seq_err_d;

    // Ready depends only on registered occupancy: no pass-through when full,
    // and nothing is accepted while reset is held.
    assign s_ready = !rst && !fifo_full;
    assign m_valid = !fifo_empty;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (s_data),
        .pop     (pop),
        .rd_data (m_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sequence checker. On a match expected+1 equals s_data+1, so the
    // next expected value is always the accepted data plus one; a mismatch
    // therefore resynchronises onto the new sequence automatically.
    always_comb begin
        seen_d     = seen_q;
        expected_d = expected_q;
        beat_cnt_d = beat_cnt_q;
        err_cnt_d  = err_cnt_q;
        seq_err_d  = 1'b0;
        if (push) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            expected_d = s_data + DATA_W'(1);
            seen_d     = 1'b1;
            if (seen_q && (s_data != expected_q)) begin
                seq_err_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q     <= 1'b0;
            expected_q <= '0;
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
            seq_err_q  <= 1'b0;
        end else begin
            seen_q     <= seen_d;
            expected_q <= expected_d;
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign beat_cnt    = beat_cnt_q;
    assign seq_err_cnt = err_cnt_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_stream_slave_fifo.sv
// tb_stream_slave_fifo: self-checking bench for stream_slave_fifo.
// Driver pushes each accepted beat into a scoreboard queue; a negedge monitor
// pops and compares whenever the DUT hands a beat downstream.
module tb_stream_slave_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  seq_err_cnt;
    logic              seq_err;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    stream_slave_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .beat_cnt    (beat_cnt),
        .seq_err_cnt (seq_err_cnt),
        .seq_err     (seq_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: a beat leaves on the edge after a negedge that
    // sees m_valid && m_ready.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h required=none", m_data);
            end else begin
                chk("sb_data", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic reset_dut();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        exp_q.delete();
        tick();
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_err_cnt", seq_err_cnt, 0);
        chk("rst_seq_err", seq_err, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", s_ready, 1'b1);
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        bit done = 0;
        s_valid = 1'b1;
        s_data  = d;
        for (int n = 0; n < 20 && !done; n++) begin
            if (s_ready) begin
                exp_q.push_back(d);
                done = 1;
            end
            tick();
        end
        s_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=%0h", d);
        end
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            tick();
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_m_valid", m_valid, 1'b0);
    endtask

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              exp_err;
        logic [CNT_W-1:0]  exp_err_cnt;
        logic [CNT_W-1:0]  exp_beat;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 32'h0000_0000, 1'b0, 16'd0, 16'd0};
        tbl[1]  = '{1'b1, 32'hFFFF_FFFE, 1'b0, 16'd0, 16'd1};
        tbl[2]  = '{1'b1, 32'hFFFF_FFFF, 1'b0, 16'd0, 16'd2};
        tbl[3]  = '{1'b0, 32'h0000_0000, 1'b0, 16'd0, 16'd2};
        tbl[4]  = '{1'b1, 32'h0000_0000, 1'b0, 16'd0, 16'd3};
        tbl[5]  = '{1'b1, 32'h0000_0001, 1'b0, 16'd0, 16'd4};
        tbl[6]  = '{1'b1, 32'h0000_0002, 1'b0, 16'd0, 16'd5};
        tbl[7]  = '{1'b1, 32'h0000_0003, 1'b0, 16'd0, 16'd6};
        tbl[8]  = '{1'b1, 32'h0000_0007, 1'b1, 16'd1, 16'd7};
        tbl[9]  = '{1'b1, 32'h0000_0008, 1'b0, 16'd1, 16'd8};
        tbl[10] = '{1'b0, 32'h0000_0009, 1'b0, 16'd1, 16'd8};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // Continuous stream 1..20 with downstream always ready.
        reset_dut();
        m_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'(i);
            chk("t1_s_ready", s_ready, 1'b1);
            if (s_ready) exp_q.push_back(DATA_W'(i));
            tick();
            chk("t1_m_valid", m_valid, 1'b1);
            chk("t1_m_data", m_data, i);
        end
        s_valid = 1'b0;
        chk("t1_beat_cnt", beat_cnt, 20);
        chk("t1_err_cnt", seq_err_cnt, 0);
        drain();

        // Backpressure: fill 1..4, beat 5 held, then release.
        reset_dut();
        m_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'(k);
            chk("t2_s_ready_fill", s_ready, 1'b1);
            if (s_ready) exp_q.push_back(DATA_W'(k));
            tick();
        end
        s_data = 32'd5;
        for (int k = 0; k < 3; k++) begin
            chk("t2_s_ready_full", s_ready, 1'b0);
            chk("t2_m_valid_held", m_valid, 1'b1);
            chk("t2_m_data_held", m_data, 1);
            tick();
        end
        m_ready = 1'b1;
        send(32'd5);
        send(32'd6);
        drain();
        chk("t2_beat_cnt", beat_cnt, 6);

        // Full FIFO, single-cycle m_ready pulse: one pop, one new accept.
        reset_dut();
        m_ready = 1'b0;
        for (int k = 10; k <= 13; k++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'(k);
            if (s_ready) exp_q.push_back(DATA_W'(k));
            tick();
        end
        s_data = 32'd14;
        chk("t3_full_ready", s_ready, 1'b0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t3_ready_after_pop", s_ready, 1'b1);
        chk("t3_head_after_pop", m_data, 11);
        if (s_ready) exp_q.push_back(32'd14);
        tick();
        s_valid = 1'b0;
        chk("t3_full_again", s_ready, 1'b0);
        chk("t3_beat_cnt", beat_cnt, 5);
        chk("t3_head_stable", m_data, 11);
        drain();

        // Sequence checker table: idle zero ignored, wrap, one break at 7.
        reset_dut();
        m_ready = 1'b1;
        for (int r = 0; r < 11; r++) begin
            s_valid = tbl[r].v;
            s_data  = tbl[r].d;
            chk("t4_s_ready", s_ready, 1'b1);
            if (tbl[r].v && s_ready) exp_q.push_back(tbl[r].d);
            tick();
            chk("t4_seq_err", seq_err, tbl[r].exp_err);
            chk("t4_err_cnt", seq_err_cnt, tbl[r].exp_err_cnt);
            chk("t4_beat_cnt", beat_cnt, tbl[r].exp_beat);
        end
        drain();

        // Reset with beats buffered, then a fresh stream from 100.
        reset_dut();
        m_ready = 1'b0;
        send(32'd50);
        send(32'd51);
        send(32'd52);
        chk("t5_m_valid_before", m_valid, 1'b1);
        reset_dut();
        m_ready = 1'b1;
        send(32'd100);
        chk("t5_first_out", m_data, 100);
        for (int j = 101; j <= 103; j++) send(DATA_W'(j));
        chk("t5_seq_err", seq_err, 1'b0);
        chk("t5_err_cnt", seq_err_cnt, 0);
        chk("t5_beat_cnt", beat_cnt, 4);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_slave_fifo.md
Name: stream_slave_fifo

Overview:
- Receiving end of the team's valid/ready stream link: accepts 32-bit beats from a stream master, buffers them in a small FIFO and re-presents them on a downstream valid/ready port.
- Also checks that accepted beats form a +1 incrementing sequence, matching the counter-style traffic our masters generate.
- Exposes a beat counter and an error counter for the bench and for debug.

Parameters:
- DATA_W, 32, width of data on both ports
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, width of accepted-beat and error counters

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- s_data  in  DATA_W  upstream data; meaningful only when s_valid=1
- s_valid  in  1  upstream beat valid
- s_ready  out  1  upstream ready (backpressure)
- m_data  out  DATA_W  downstream data (head of FIFO)
- m_valid  out  1  downstream beat valid
- m_ready  in  1  downstream ready
- beat_cnt  out  CNT_W  number of accepted upstream beats
- seq_err_cnt  out  CNT_W  number of sequence breaks detected
- seq_err  out  1  one-cycle pulse on a sequence break

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. `rst` is sampled only on a `clk` rising edge.
- Accept (push) on a cycle where s_valid && s_ready.
- Pop on a cycle where m_valid && m_ready.
- s_ready = !rst && (count < DEPTH). It is derived combinationally from the registered count and does not depend on s_valid or m_ready. No same-cycle pass-through when full.
- m_valid = (count != 0). m_data = mem[rd_ptr], first-word fall-through. Both are stable while m_valid=1 && m_ready=0.
- Latency: a beat accepted at edge N appears on m_data/m_valid after edge N (1 cycle).
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - Full: no push possible (s_ready=0); a pop frees an entry, and s_ready rises the next cycle.
  - Empty: no pop possible; a push makes m_valid=1 the next cycle.
- Sequence checker (registers `seen`, `expected`):
  - On accept with seen=0: seen←1, expected←s_data+1, no error.
  - On accept with seen=1 and s_data≠expected: seq_err=1 for that following cycle, seq_err_cnt increments (saturates at all-ones), and expected←s_data+1 (resync).
  - On accept with seen=1 and s_data==expected: expected←expected+1.
  - expected arithmetic is modulo 2^DATA_W; 0xFFFFFFFF followed by 0x00000000 is not an error.
- beat_cnt increments on every accept and wraps modulo 2^CNT_W.
- s_data is ignored whenever s_valid=0, including during the master's idle/zero phase.
- Reset values: count=0, rd_ptr=wr_ptr=0, m_valid=0, s_ready=0 while rst=1 and 1 in the first cycle after, beat_cnt=0, seq_err_cnt=0, seq_err=0, seen=0, expected=0. m_data is don't-care while m_valid=0.
- Reset mid-operation: buffered beats are discarded. Any upstream beat presented during rst is not accepted. After reset, the first accepted beat re-seeds the checker.

Decomposition:
- Shared package `stream_pkg`: DATA_W default, the counter width, and the helper for log2(DEPTH).
- Sub-module `sync_fifo` (storage, pointers, count, full/empty) instantiated once.
- Handshake mapping, sequence checker and counters stay in the top level.

Test Plan:
- Continuous stream 1,2,3…20 with m_ready=1 -> s_ready stays 1; m_data shows 1..20 each one cycle after acceptance; beat_cnt=20; seq_err_cnt=0.
- m_ready=0, push 1..6 -> s_ready drops after 4 accepts; beats 5,6 held by the master. Then m_ready=1 -> output 1..6 in order, no loss or duplication.
- Full FIFO with s_valid=1 and m_ready pulsed one cycle -> exactly one pop; s_ready=1 on the next cycle; one new accept; count back to 4.
- Stream 1,2,3,7,8 -> single seq_err pulse after accepting 7; seq_err_cnt=1; 8 not flagged.
- Stream 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 -> no error (wrap-around); s_data=0 with s_valid=0 beforehand is ignored.
- rst asserted for one cycle with 3 beats buffered -> m_valid=0, counters 0, s_ready=0 during rst. Next stream starting at 100 -> no error, 100 output first.
